// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared defaults and clear-engine state encoding for the register file
package rf_pkg;

  localparam int RF_NREGS  = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write bits with set-over-clear priority and busy lookup
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sweep_en,
  input  logic [ADDR_W-1:0]     sweep_addr,
  input  logic [NWR-1:0]        wr_ok,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic                  mark_ok,
  input  logic [ADDR_W-1:0]     mark_addr,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD-1:0]        busy
);

  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pending_next;

  // Mark is applied last so a newly issued producer outranks a retiring one.
  always_comb begin
    pending_next = pending;
    for (int r = 0; r < NREGS; r++) begin
      if (sweep_en && sweep_addr == ADDR_W'(r)) pending_next[r] = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j] && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) pending_next[r] = 1'b0;
      end
      if (mark_ok && mark_addr == ADDR_W'(r)) pending_next[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_next;
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic              bit_v;
    busy  = '0;
    a     = '0;
    hit   = 1'b0;
    bit_v = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      a     = rd_addr[i*ADDR_W +: ADDR_W];
      hit   = 1'b0;
      bit_v = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
        if (a == ADDR_W'(r)) bit_v = pending[r];
      end
      for (int j = 0; j < NWR; j++) begin
        if (BYPASS != 0 && wr_ok[j] && wr_addr[j*ADDR_W +: ADDR_W] == a) hit = 1'b1;
      end
      if (ZERO_REG != 0 && a == '0) bit_v = 1'b0;
      busy[i] = bit_v & ~hit;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with bypass, zero register and sequential clear engine
module regfile_mp
  import rf_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DATA_W   = RF_DATA_W,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic                  mark_en,
  input  logic [ADDR_W-1:0]     mark_addr,
  input  logic                  clear_req,
  output logic                  init_done
);

  rf_state_e         state;
  rf_state_e         state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;
  logic              ready;
  logic [NWR-1:0]    wr_ok;
  logic              mark_ok;
  logic [NRD-1:0]    sb_busy;
  logic [DATA_W-1:0] regs [NREGS];

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < NREGS) && !(ZERO_REG != 0 && a == '0);
  endfunction

  assign ready     = (state == ST_READY);
  assign init_done = ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_INIT: begin
        if (cnt == ADDR_W'(NREGS - 1)) begin
          state_next = ST_READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_next = ST_INIT;
          cnt_next   = '0;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  // A clear request also kills writes and marks in its own cycle.
  always_comb begin
    wr_ok = '0;
    for (int j = 0; j < NWR; j++) begin
      wr_ok[j] = ready && !clear_req && wr_en[j] && addr_ok(wr_addr[j*ADDR_W +: ADDR_W]);
    end
    mark_ok = ready && !clear_req && mark_en && addr_ok(mark_addr);
  end

  // No reset on the array: the sweep zeroes it before any read is allowed.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (!ready && cnt == ADDR_W'(r)) regs[r] <= '0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j] && wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) regs[r] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    rd_data = '0;
    a       = '0;
    d       = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rd_addr[i*ADDR_W +: ADDR_W];
      d = '0;
      if (ready && addr_ok(a)) begin
        for (int r = 0; r < NREGS; r++) begin
          if (a == ADDR_W'(r)) d = regs[r];
        end
        for (int j = 0; j < NWR; j++) begin
          if (BYPASS != 0 && wr_ok[j] && wr_addr[j*ADDR_W +: ADDR_W] == a) d = wr_data[j*DATA_W +: DATA_W];
        end
      end
      rd_data[i*DATA_W +: DATA_W] = d;
    end
  end

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ADDR_W   (ADDR_W),
    .NRD      (NRD),
    .NWR      (NWR),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .sweep_en   (!ready),
    .sweep_addr (cnt),
    .wr_ok      (wr_ok),
    .wr_addr    (wr_addr),
    .mark_ok    (mark_ok),
    .mark_addr  (mark_addr),
    .rd_addr    (rd_addr),
    .busy       (sb_busy)
  );

  // During the sweep every read reports busy so the pipeline holds off.
  assign rd_busy = ready ? sb_busy : '1;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - randomized bench for regfile_mp against a behavioural model, bypass and no-bypass instances
module tb_regfile_mp;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0] rd_addr;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              mark_en;
  logic [AW-1:0]     mark_addr;
  logic              clear_req;
  logic [NRD*DW-1:0] rd_data0, rd_data1;
  logic [NRD-1:0]    rd_busy0, rd_busy1;
  logic              init_done0, init_done1;

  regfile_mp #(.NREGS(32), .ADDR_W(AW), .DATA_W(DW), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mark_en(mark_en), .mark_addr(mark_addr),
    .clear_req(clear_req), .init_done(init_done0)
  );

  regfile_mp #(.NREGS(24), .ADDR_W(AW), .DATA_W(DW), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1)) u_nob (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .mark_en(mark_en), .mark_addr(mark_addr),
    .clear_req(clear_req), .init_done(init_done1)
  );

  int compared   = 0;
  int mismatched = 0;
  int conflicts  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one architectural state per instance.
  int          nregs [2] = '{32, 24};
  bit          byp   [2] = '{1'b1, 1'b0};
  logic [DW-1:0] m_regs [2][32];
  bit          m_pend [2][32];
  bit          m_ready [2];
  int          m_cnt   [2];

  function automatic bit valid(int k, int a);
    return a != 0 && a < nregs[k];
  endfunction

  function automatic int wa(int j);
    return int'(wr_addr[j*AW +: AW]);
  endfunction

  function automatic logic [DW-1:0] wd(int j);
    return wr_data[j*DW +: DW];
  endfunction

  function automatic bit live(int k, int j, int a);
    return m_ready[k] && !clear_req && wr_en[j] && valid(k, wa(j)) && wa(j) == a;
  endfunction

  function automatic logic [DW-1:0] exp_data(int k, int a);
    logic [DW-1:0] v;
    if (!m_ready[k] || !valid(k, a)) return '0;
    v = m_regs[k][a];
    if (byp[k]) for (int j = 0; j < NWR; j++) if (live(k, j, a)) v = wd(j);
    return v;
  endfunction

  function automatic bit exp_busy(int k, int a);
    if (!m_ready[k]) return 1'b1;
    if (!valid(k, a)) return 1'b0;
    if (byp[k]) for (int j = 0; j < NWR; j++) if (live(k, j, a)) return 1'b0;
    return m_pend[k][a];
  endfunction

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_ready[k] = 1'b0;
      m_cnt[k]   = 0;
      for (int r = 0; r < 32; r++) begin
        m_regs[k][r] = '0;
        m_pend[k][r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_ready[k] = 1'b0;
        m_cnt[k]   = 0;
        for (int r = 0; r < 32; r++) m_pend[k][r] = 1'b0;
      end else if (!m_ready[k]) begin
        m_regs[k][m_cnt[k]] = '0;
        m_pend[k][m_cnt[k]] = 1'b0;
        if (m_cnt[k] == nregs[k] - 1) begin
          m_ready[k] = 1'b1;
          m_cnt[k]   = 0;
        end else begin
          m_cnt[k]++;
        end
      end else if (clear_req) begin
        m_ready[k] = 1'b0;
        m_cnt[k]   = 0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && valid(k, wa(j))) begin
            m_regs[k][wa(j)] = wd(j);
            m_pend[k][wa(j)] = 1'b0;
          end
        end
        if (mark_en && valid(k, int'(mark_addr))) m_pend[k][mark_addr] = 1'b1;
      end
    end
    if (!rst && wr_en == 2'b11 && wr_addr[AW-1:0] == wr_addr[2*AW-1:AW] && conflicts < 4) begin
      conflicts++;
      $display("note: multi-port write conflict on x%0d at %0t", wr_addr[AW-1:0], $time);
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [NRD*DW-1:0] ed;
      logic [NRD-1:0]    eb;
      logic              ei;
      int                a;
      ei = rst ? 1'b0 : m_ready[k];
      for (int i = 0; i < NRD; i++) begin
        a = int'(rd_addr[i*AW +: AW]);
        ed[i*DW +: DW] = rst ? '0 : exp_data(k, a);
        eb[i]          = rst ? 1'b1 : exp_busy(k, a);
      end
      check($sformatf("u%0d init_done", k), (k == 0) ? init_done0 : init_done1, ei);
      check($sformatf("u%0d rd_data", k), (k == 0) ? rd_data0 : rd_data1, ed);
      check($sformatf("u%0d rd_busy", k), (k == 0) ? rd_busy0 : rd_busy1, eb);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_check(input string tag);
    for (int c = 1; c <= 32; c++) begin
      step();
      #1;
      if (c < 32) begin
        check({tag, " init_done low"}, init_done0, 1'b0);
        check({tag, " rd_busy stall"}, rd_busy0, 2'b11);
      end else begin
        check({tag, " init_done rises"}, init_done0, 1'b1);
        check({tag, " rd_busy clear"}, rd_busy0, 2'b00);
      end
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 31));
  endfunction

  initial begin
    rd_addr   = {AW'(5), AW'(5)};
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    mark_en   = 1'b0;
    mark_addr = '0;
    clear_req = 1'b0;
    rst       = 1'b1;
    repeat (3) step();
    #1;
    check("reset init_done", init_done0, 1'b0);
    check("reset rd_busy", rd_busy0, 2'b11);
    rst = 1'b0;
    sweep_check("boot");
    check("boot x5 reads zero", rd_data0[DW-1:0], 32'h0);

    wr_en   = 2'b11;
    wr_addr = {AW'(3), AW'(3)};
    wr_data = {32'h2222, 32'h1111};
    rd_addr = {AW'(5), AW'(3)};
    #1 check("same-cycle port1 wins", rd_data0[DW-1:0], 32'h2222);
    step();
    wr_en = '0;
    #1 check("array port1 wins", rd_data0[DW-1:0], 32'h2222);

    wr_en     = 2'b01;
    wr_addr   = {AW'(0), AW'(0)};
    wr_data   = {32'h0, 32'hDEAD};
    mark_en   = 1'b1;
    mark_addr = AW'(0);
    rd_addr   = {AW'(0), AW'(0)};
    #1 check("x0 bypass blocked", rd_data0[DW-1:0], 32'h0);
    check("x0 never busy", rd_busy0, 2'b00);
    step();
    wr_en   = '0;
    mark_en = 1'b0;
    #1 check("x0 stays zero", rd_data0[DW-1:0], 32'h0);
    check("x0 still not busy", rd_busy0[0], 1'b0);

    mark_en   = 1'b1;
    mark_addr = AW'(7);
    rd_addr   = {AW'(5), AW'(7)};
    #1 check("x7 idle before mark edge", rd_busy0[0], 1'b0);
    step();
    mark_en = 1'b0;
    #1 check("x7 busy after mark", rd_busy0[0], 1'b1);
    wr_en     = 2'b01;
    wr_addr   = {AW'(0), AW'(7)};
    wr_data   = {32'h0, 32'hABCD};
    mark_en   = 1'b1;
    #1 check("x7 bypass data", rd_data0[DW-1:0], 32'hABCD);
    check("x7 bypass hides busy", rd_busy0[0], 1'b0);
    step();
    wr_en   = '0;
    mark_en = 1'b0;
    #1 check("x7 re-mark wins", rd_busy0[0], 1'b1);
    check("x7 array data", rd_data0[DW-1:0], 32'hABCD);

    wr_en   = 2'b01;
    wr_addr = {AW'(0), AW'(4)};
    wr_data = {32'h0, 32'h9};
    rd_addr = {AW'(5), AW'(4)};
    #1 check("no-bypass old value", rd_data1[DW-1:0], 32'h0);
    step();
    wr_en = '0;
    #1 check("no-bypass new value", rd_data1[DW-1:0], 32'h9);

    wr_en     = 2'b01;
    wr_addr   = {AW'(0), AW'(30)};
    wr_data   = {32'h0, 32'h77};
    mark_en   = 1'b1;
    mark_addr = AW'(30);
    rd_addr   = {AW'(30), AW'(30)};
    step();
    wr_en   = '0;
    mark_en = 1'b0;
    #1 check("out-of-range read", rd_data1[2*DW-1:DW], 32'h0);
    check("out-of-range busy", rd_busy1[1], 1'b0);

    wr_en   = 2'b01;
    wr_addr = {AW'(0), AW'(10)};
    wr_data = {32'h0, 32'h5};
    rd_addr = {AW'(5), AW'(10)};
    step();
    wr_en = '0;
    #1 check("x10 written", rd_data0[DW-1:0], 32'h5);
    clear_req = 1'b1;
    #1 check("clear cycle still ready", init_done0, 1'b1);
    step();
    clear_req = 1'b0;
    #1 check("clear drops init_done", init_done0, 1'b0);
    for (int c = 1; c <= 32; c++) begin
      step();
      #1 check("clear sweep init_done", init_done0, (c == 32) ? 1'b1 : 1'b0);
    end
    check("x10 cleared", rd_data0[DW-1:0], 32'h0);

    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (12) step();
    rst = 1'b1;
    #1 check("mid-sweep rst init_done", init_done0, 1'b0);
    step();
    step();
    rst = 1'b0;
    sweep_check("restart");

    for (int c = 0; c < 3000; c++) begin
      rd_addr   = {rnd_addr(), rnd_addr()};
      wr_en     = 2'($urandom_range(0, 3));
      wr_addr   = {rnd_addr(), rnd_addr()};
      wr_data   = {$urandom, $urandom};
      mark_en   = 1'($urandom_range(0, 1));
      mark_addr = rnd_addr();
      clear_req = ($urandom_range(0, 149) == 0);
      rst       = ($urandom_range(0, 699) == 0);
      step();
    end

    rst       = 1'b0;
    wr_en     = '0;
    mark_en   = 1'b0;
    clear_req = 1'b0;
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
